pix_writer: RTL and testbench
=============================

// Module: pix_writer
// PURPOSE
//  Sink end of the pixel-scan path: accepts computed Julia pixel results (x, y, iteration count)
//  from the escape-time pipeline via valid/ready. Converts each pixel to a linear frame-buffer address,
//  buffers it in a small FIFO and writes it to SRAM over a req/ack port.
//  Counts completed writes and flags frame completion to the top-level controller.
// PARAMETERS
//  NUM_X_BITS  10   width of in_x
//  NUM_Y_BITS  10   width of in_y
//  DATA_BITS   8    iteration-count / pixel data width
//  ADDR_BITS   19   frame-buffer address width
//  IMG_WIDTH   640  pixels per row (valid x: 0..IMG_WIDTH-1)
//  IMG_HEIGHT  480  rows per frame (valid y: 0..IMG_HEIGHT-1)
//  FIFO_DEPTH  4    pending-write entries, power of 2, >=2
// PORTS
//  clk          in   1           single clock, all logic on rising edge
//  rst          in   1           reset, synchronous, active-high
//  frame_start  in   1           1-cycle pulse: arm for a new frame
//  in_valid     in   1           pixel result valid
//  in_ready     out  1           block can accept pixel this cycle
//  in_x         in   NUM_X_BITS  pixel column
//  in_y         in   NUM_Y_BITS  pixel row
//  in_iter      in   DATA_BITS   pixel value (iteration count)
//  mem_req      out  1           SRAM write request
//  mem_addr     out  ADDR_BITS   write address = in_y*IMG_WIDTH + in_x
//  mem_wdata    out  DATA_BITS   write data
//  mem_ack      in   1           SRAM accepted the write this cycle
//  pix_count    out  ADDR_BITS   SRAM writes completed this frame
//  coord_err    out  1           sticky: out-of-range pixel dropped this frame
//  frame_done   out  1           level: IMG_WIDTH*IMG_HEIGHT writes completed
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, FIFO empty, all outputs 0. Any mem_req in flight is dropped.
//  FSM states and transitions:
//   - IDLE -> ACTIVE on frame_start. Entering ACTIVE clears pix_count, coord_err and frame_done.
//   - ACTIVE -> DONE on the ack that takes pix_count to IMG_WIDTH*IMG_HEIGHT.
//   - DONE -> ACTIVE on frame_start; same clears apply.
//   - frame_start while ACTIVE: ignored.
//  in_ready = (state==ACTIVE) && !fifo_full. Decided from registered count; no same-cycle pop pass-through.
//  Accept when in_valid && in_ready:
//   - in-range pixel: push {addr, in_iter}. The multiply-add result is registered, so the entry becomes
//     visible as FIFO head at accept+1.
//   - in_x>=IMG_WIDTH or in_y>=IMG_HEIGHT: consumed, not pushed, not counted; coord_err<=1.
//  Address arithmetic: computed at full width, truncated to ADDR_BITS. Parameters guarantee no overflow.
//  Write port: mem_req = fifo_not_empty. mem_addr and mem_wdata are driven from the FIFO head and hold
//  stable while mem_req=1 && !mem_ack.
//  On mem_req && mem_ack: pop, and pix_count+1 in the same edge. If the FIFO is still non-empty,
//  mem_req stays high with the next entry. Back-to-back one write per cycle when mem_ack is tied high.
//  Latency: the earliest mem_req for a pixel is 1 cycle after acceptance (empty FIFO).
//  Push and pop in the same cycle: occupancy is unchanged, and ordering is strict FIFO.
//  Duplicate coordinates: each write is counted; no uniqueness check.
//  Writes still drain in DONE; excess writes after the count is reached are not counted.
//  frame_done: registered, asserts the cycle after the final ack, held until the next ACTIVE entry or rst.
// STRUCTURE
//  julia_pkg:
//   - pw_state_t enum {IDLE, ACTIVE, DONE}
//   - IMG_WIDTH / IMG_HEIGHT defaults
//   - PIX_TOTAL = IMG_WIDTH*IMG_HEIGHT
//  Sub-module pix_wr_fifo: synchronous FIFO, width ADDR_BITS+DATA_BITS, depth FIFO_DEPTH.
//   - outputs: full, empty, head, count
//   - pointers wrap modulo FIFO_DEPTH
//  pix_writer holds: FSM, address register, pix_count, coord_err, handshake glue.
// TESTING
//  1. rst, then frame_start, then (x=3, y=2, iter=0x55) with mem_ack=1
//     -> mem_req at accept+1, addr=1283, data=0x55, pix_count=1.
//  2. mem_ack held 0 for 10 cycles while feeding 6 pixels (FIFO_DEPTH=4)
//     -> in_ready drops after 4 accepts; addr/wdata stable; in-order drain once ack=1.
//  3. Pixel x=640, y=0 -> not written, pix_count unchanged, coord_err=1 until next frame_start.
//  4. Full raster with small params (IMG_WIDTH=4, IMG_HEIGHT=3), ack random 50%
//     -> 12 writes at addr 0..11, frame_done 1 cycle after 12th ack.
//  5. rst asserted mid-transfer with mem_req=1 and 3 entries queued
//     -> next cycle mem_req=0, in_ready=0, pix_count=0; in_valid ignored until frame_start.
//  6. frame_start while ACTIVE -> ignored. frame_start in DONE -> frame_done=0, pix_count=0, in_ready=1.

Source files
------------

// File: rtl/julia_pkg.sv
// Shared types and default frame geometry for the Julia pixel-scan path.
package julia_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } pw_state_t;

   localparam int DEF_IMG_WIDTH  = 640;
   localparam int DEF_IMG_HEIGHT = 480;
   localparam int PIX_TOTAL      = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;

endpackage

// File: rtl/pix_wr_fifo.sv
// Small synchronous FIFO holding pending {address, data} frame-buffer writes.
module pix_wr_fifo #(
   parameter int WIDTH = 27,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_BITS = $clog2(DEPTH);
   localparam int CNT_BITS = PTR_BITS + 1;

   logic [WIDTH-1:0]    mem [DEPTH];
   logic [PTR_BITS-1:0] wr_ptr;
   logic [PTR_BITS-1:0] rd_ptr;
   logic                do_push;
   logic                do_pop;

   assign full    = (count == CNT_BITS'(DEPTH));
   assign empty   = (count == CNT_BITS'(0));
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage is cleared on reset so the write port shows zeros, not stale entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PTR_BITS'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_BITS'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_BITS'(1);
            2'b01:   count <= count - CNT_BITS'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pix_writer.sv
// Pixel sink: maps (x, y) to a linear frame-buffer address, queues the write
// and drives the SRAM req/ack port, tracking per-frame completion.
module pix_writer
   import julia_pkg::*;
#(
   parameter int NUM_X_BITS = 10,
   parameter int NUM_Y_BITS = 10,
   parameter int DATA_BITS  = 8,
   parameter int ADDR_BITS  = 19,
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NUM_X_BITS-1:0] in_x,
   input  logic [NUM_Y_BITS-1:0] in_y,
   input  logic [DATA_BITS-1:0]  in_iter,
   output logic                  mem_req,
   output logic [ADDR_BITS-1:0]  mem_addr,
   output logic [DATA_BITS-1:0]  mem_wdata,
   input  logic                  mem_ack,
   output logic [ADDR_BITS-1:0]  pix_count,
   output logic                  coord_err,
   output logic                  frame_done
);

   localparam int ENTRY_BITS = ADDR_BITS + DATA_BITS;
   localparam logic [ADDR_BITS-1:0] FRAME_PIX = ADDR_BITS'(IMG_WIDTH * IMG_HEIGHT);

   pw_state_t                 state;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [ENTRY_BITS-1:0]     fifo_head;
   logic [ENTRY_BITS-1:0]     fifo_din;
   logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;
   logic                      accept;
   logic                      in_range;
   logic                      push;
   logic                      pop;
   logic [ADDR_BITS-1:0]      lin_addr;

   assign in_ready = (state == ACTIVE) && !fifo_full;
   assign accept   = in_valid && in_ready;
   assign in_range = (32'(in_x) < 32'(IMG_WIDTH)) && (32'(in_y) < 32'(IMG_HEIGHT));
   // Full-width multiply-add; the FIFO entry itself is the register stage.
   assign lin_addr = ADDR_BITS'(32'(in_y) * 32'(IMG_WIDTH) + 32'(in_x));
   assign fifo_din = {lin_addr, in_iter};
   assign push     = accept && in_range;
   assign pop      = mem_req && mem_ack;

   assign mem_req   = !fifo_empty;
   assign mem_addr  = fifo_head[ENTRY_BITS-1:DATA_BITS];
   assign mem_wdata = fifo_head[DATA_BITS-1:0];

   pix_wr_fifo #(
      .WIDTH (ENTRY_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (fifo_din),
      .pop   (pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head),
      .count (unused_fifo_count)
   );

   // Frame FSM with its registered status outputs; writes draining in DONE are not counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pix_count  <= '0;
         coord_err  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (frame_start) begin
                  state      <= ACTIVE;
                  pix_count  <= '0;
                  coord_err  <= 1'b0;
                  frame_done <= 1'b0;
               end
            end
            ACTIVE: begin
               if (accept && !in_range) begin
                  coord_err <= 1'b1;
               end
               if (pop) begin
                  pix_count <= pix_count + ADDR_BITS'(1);
                  if (pix_count == FRAME_PIX - ADDR_BITS'(1)) begin
                     state      <= DONE;
                     frame_done <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pix_writer.sv
// Scoreboard bench for pix_writer: a default 640x480 instance and a 4x3 instance for a full raster.
module tb_pix_writer;

   logic        clk = 1'b0;
   logic        rst;

   logic        frame_start, in_valid, in_ready, mem_req, mem_ack, coord_err, frame_done;
   logic [9:0]  in_x, in_y;
   logic [7:0]  in_iter, mem_wdata;
   logic [18:0] mem_addr, pix_count;

   logic        s_frame_start, s_in_valid, s_in_ready, s_mem_req, s_mem_ack, s_coord_err, s_frame_done;
   logic [9:0]  s_in_x, s_in_y;
   logic [7:0]  s_in_iter, s_mem_wdata;
   logic [18:0] s_mem_addr, s_pix_count;

   logic [26:0] q [$];
   logic [26:0] s_q [$];
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   pix_writer u_dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_iter(in_iter), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .pix_count(pix_count), .coord_err(coord_err),
      .frame_done(frame_done)
   );

   pix_writer #(.IMG_WIDTH(4), .IMG_HEIGHT(3)) u_small (
      .clk(clk), .rst(rst), .frame_start(s_frame_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_x(s_in_x), .in_y(s_in_y), .in_iter(s_in_iter), .mem_req(s_mem_req), .mem_addr(s_mem_addr),
      .mem_wdata(s_mem_wdata), .mem_ack(s_mem_ack), .pix_count(s_pix_count), .coord_err(s_coord_err),
      .frame_done(s_frame_done)
   );

   // Inputs are set after a negedge; tick scores the coming edge, then waits for the next negedge.
   task automatic tick();
      logic [26:0] exp_e;
      #1;
      if (!rst && mem_req && mem_ack) begin
         vectors++;
         if (q.size() == 0) begin
            miscompares++;
            $display("FAIL write_unexpected got addr=%0d data=%0h, none expected", mem_addr, mem_wdata);
         end else begin
            exp_e = q.pop_front();
            if ({mem_addr, mem_wdata} !== exp_e) begin
               miscompares++;
               $display("FAIL write_order got addr=%0d data=%0h exp addr=%0d data=%0h",
                        mem_addr, mem_wdata, exp_e[26:8], exp_e[7:0]);
            end
         end
      end
      if (!rst && in_valid && in_ready && in_x < 10'd640 && in_y < 10'd480)
         q.push_back({19'(int'(in_y) * 640 + int'(in_x)), in_iter});
      if (!rst && s_mem_req && s_mem_ack) begin
         vectors++;
         if (s_q.size() == 0) begin
            miscompares++;
            $display("FAIL small_write_unexpected got addr=%0d data=%0h", s_mem_addr, s_mem_wdata);
         end else begin
            exp_e = s_q.pop_front();
            if ({s_mem_addr, s_mem_wdata} !== exp_e) begin
               miscompares++;
               $display("FAIL small_write_order got addr=%0d data=%0h exp addr=%0d data=%0h",
                        s_mem_addr, s_mem_wdata, exp_e[26:8], exp_e[7:0]);
            end
         end
      end
      if (!rst && s_in_valid && s_in_ready && s_in_x < 10'd4 && s_in_y < 10'd3)
         s_q.push_back({19'(int'(s_in_y) * 4 + int'(s_in_x)), s_in_iter});
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      in_valid = 1'b1; in_x = 10'd1; in_y = 10'd1; in_iter = 8'h11;
      tick();
      in_valid = 1'b0;
      tick();
      vectors++;
      if ({in_ready, mem_req, mem_addr, mem_wdata, pix_count, coord_err, frame_done} !== 50'd0) begin
         miscompares++;
         $display("FAIL reset_state got rdy=%b req=%b addr=%0d data=%0h cnt=%0d err=%b done=%b exp all 0",
                  in_ready, mem_req, mem_addr, mem_wdata, pix_count, coord_err, frame_done);
      end
      vectors++;
      if ({s_in_ready, s_mem_req, s_pix_count, s_coord_err, s_frame_done} !== 23'd0) begin
         miscompares++;
         $display("FAIL reset_small got rdy=%b req=%b cnt=%0d exp all 0", s_in_ready, s_mem_req, s_pix_count);
      end
   endtask

   task automatic test_single();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL single_ready got %b exp 1", in_ready);
      end
      in_valid = 1'b1; in_x = 10'd3; in_y = 10'd2; in_iter = 8'h55; mem_ack = 1'b1;
      tick();
      in_valid = 1'b0;
      vectors++;
      if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 19'd1283, 8'h55}) begin
         miscompares++;
         $display("FAIL single_latency got req=%b addr=%0d data=%0h exp req=1 addr=1283 data=55",
                  mem_req, mem_addr, mem_wdata);
      end
      tick();
      vectors++;
      if ({mem_req, pix_count} !== {1'b0, 19'd1}) begin
         miscompares++;
         $display("FAIL single_count got req=%b cnt=%0d exp req=0 cnt=1", mem_req, pix_count);
      end
   endtask

   task automatic test_backpressure();
      int acc = 0;
      mem_ack = 1'b0;
      for (int c = 0; c < 10; c++) begin
         in_valid = (acc < 6); in_x = 10'(10 + acc); in_y = 10'(5 + acc); in_iter = 8'(acc * 17 + 1);
         if (in_valid && in_ready) acc++;
         tick();
         vectors++;
         if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 19'd3210, 8'd1}) begin
            miscompares++;
            $display("FAIL bp_hold cycle %0d got req=%b addr=%0d data=%0h exp req=1 addr=3210 data=1",
                     c, mem_req, mem_addr, mem_wdata);
         end
      end
      vectors++;
      if (acc !== 4 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_full got accepts=%0d rdy=%b exp accepts=4 rdy=0", acc, in_ready);
      end
      mem_ack = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (acc == 6 && q.size() == 0) break;
         in_valid = (acc < 6); in_x = 10'(10 + acc); in_y = 10'(5 + acc); in_iter = 8'(acc * 17 + 1);
         if (in_valid && in_ready) acc++;
         tick();
      end
      in_valid = 1'b0;
      vectors++;
      if (acc !== 6 || q.size() != 0 || mem_req !== 1'b0 || pix_count !== 19'd7) begin
         miscompares++;
         $display("FAIL bp_drain got accepts=%0d pending=%0d req=%b cnt=%0d exp 6/0/0/7",
                  acc, q.size(), mem_req, pix_count);
      end
   endtask

   task automatic test_out_of_range();
      in_valid = 1'b1; in_x = 10'd640; in_y = 10'd0; in_iter = 8'hAA;
      tick();
      in_x = 10'd0; in_y = 10'd480;
      tick();
      in_valid = 1'b0;
      tick();
      vectors++;
      if ({mem_req, pix_count, coord_err} !== {1'b0, 19'd7, 1'b1}) begin
         miscompares++;
         $display("FAIL oor_drop got req=%b cnt=%0d err=%b exp req=0 cnt=7 err=1", mem_req, pix_count, coord_err);
      end
      in_valid = 1'b1; in_x = 10'd639; in_y = 10'd479; in_iter = 8'h3C;
      tick();
      in_valid = 1'b0;
      tick();
      vectors++;
      if ({pix_count, coord_err} !== {19'd8, 1'b1}) begin
         miscompares++;
         $display("FAIL oor_sticky got cnt=%0d err=%b exp cnt=8 err=1", pix_count, coord_err);
      end
   endtask

   task automatic test_frame_start_active();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      vectors++;
      if ({pix_count, coord_err, in_ready} !== {19'd8, 1'b1, 1'b1}) begin
         miscompares++;
         $display("FAIL fs_active got cnt=%0d err=%b rdy=%b exp cnt=8 err=1 rdy=1", pix_count, coord_err, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      mem_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_x = 10'(k); in_y = 10'd7; in_iter = 8'(k + 200);
         tick();
      end
      vectors++;
      if (mem_req !== 1'b1) begin
         miscompares++;
         $display("FAIL rmid_pending got req=%b exp 1", mem_req);
      end
      rst = 1'b1; mem_ack = 1'b1;
      tick();
      rst = 1'b0;
      q.delete();
      vectors++;
      if ({mem_req, in_ready, pix_count, coord_err} !== 22'd0) begin
         miscompares++;
         $display("FAIL rmid_clear got req=%b rdy=%b cnt=%0d err=%b exp all 0", mem_req, in_ready, pix_count, coord_err);
      end
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_x = 10'(k); in_y = 10'd9; in_iter = 8'h77;
         tick();
      end
      in_valid = 1'b0;
      vectors++;
      if ({mem_req, pix_count} !== 20'd0) begin
         miscompares++;
         $display("FAIL rmid_idle got req=%b cnt=%0d exp req=0 cnt=0", mem_req, pix_count);
      end
   endtask

   task automatic test_full_raster();
      int i = 0;
      int acks = 0;
      s_frame_start = 1'b1;
      tick();
      s_frame_start = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (acks == 12) break;
         s_in_valid = (i < 12); s_in_x = 10'(i % 4); s_in_y = 10'(i / 4); s_in_iter = 8'(i + 100);
         s_mem_ack = 1'($urandom_range(0, 1));
         if (s_in_valid && s_in_ready) i++;
         if (s_mem_req && s_mem_ack) acks++;
         tick();
         vectors++;
         if (s_pix_count !== 19'(acks) || s_frame_done !== (acks == 12)) begin
            miscompares++;
            $display("FAIL raster_progress got cnt=%0d done=%b exp cnt=%0d done=%b",
                     s_pix_count, s_frame_done, acks, (acks == 12));
         end
      end
      s_in_valid = 1'b0; s_mem_ack = 1'b0;
      vectors++;
      if (acks !== 12 || s_q.size() != 0 || s_in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL raster_end got acks=%0d pending=%0d rdy=%b exp 12/0/0", acks, s_q.size(), s_in_ready);
      end
   endtask

   task automatic test_done_restart();
      tick();
      tick();
      vectors++;
      if ({s_frame_done, s_pix_count} !== {1'b1, 19'd12}) begin
         miscompares++;
         $display("FAIL done_hold got done=%b cnt=%0d exp done=1 cnt=12", s_frame_done, s_pix_count);
      end
      s_frame_start = 1'b1;
      tick();
      s_frame_start = 1'b0;
      vectors++;
      if ({s_frame_done, s_pix_count, s_in_ready} !== {1'b0, 19'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL done_restart got done=%b cnt=%0d rdy=%b exp done=0 cnt=0 rdy=1",
                  s_frame_done, s_pix_count, s_in_ready);
      end
   endtask

   initial begin
      rst = 1'b1;
      frame_start = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_iter = '0; mem_ack = 1'b0;
      s_frame_start = 1'b0; s_in_valid = 1'b0; s_in_x = '0; s_in_y = '0; s_in_iter = '0; s_mem_ack = 1'b0;
      test_reset();
      test_single();
      test_backpressure();
      test_out_of_range();
      test_frame_start_active();
      test_reset_mid();
      test_full_raster();
      test_done_restart();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
